edge_accum_scan: RTL and testbench
==================================

# edge_accum_scan

Parametrised sticky edge-mask accumulator with registered word readout and a sequential hit-scan engine. Successor to the fixed 2048-bit accumulate/two-level-mux checker. Collects edge masks over many cycles, serves any WORD_W slice with a one-cycle registered read, and walks the accumulator to stream out the index of every set bit over a valid/ready handshake. Sits between the edge-mask producer and the result/host readout path.

## Interface
- MASK_W, 2048, accumulator width; must be a multiple of WORD_W.
- WORD_W, 32, readout and scan word width; power of two.
- Derived constants: NWORDS = MASK_W/WORD_W; IDX_W = clog2(NWORDS); BIT_W = clog2(MASK_W).
- Clock and reset: one clock; reset is synchronous and active-high.
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- mask_vld  in  1  accumulate strobe.
- mask_in  in  MASK_W  bits to OR into the accumulator.
- clr  in  1  clear the accumulator and abort any scan.
- rd_req  in  1  word read request.
- rd_idx  in  IDX_W  word index to read.
- rd_vld  out  1  read data valid.
- rd_data  out  WORD_W  word read.
- scan_start  in  1  start a scan; ignored while scan_busy is high.
- scan_busy  out  1  scan in progress.
- hit_vld  out  1  hit_idx valid.
- hit_rdy  in  1  consumer accepts the hit.
- hit_idx  out  BIT_W  absolute index of the set bit.
- scan_done  out  1  one-cycle pulse at scan end.
- scan_abort  out  1  qualifies scan_done: scan ended because of clr.
- hit_cnt  out  BIT_W+1  hits accepted in the current or last scan.
- any_set  out  1  OR-reduction of the accumulator.

## Operation
- Update priority: RST > clr > normal.
- Normal update: acc <= acc | (mask_vld ? mask_in : 0).
- Read: rd_req samples acc before this cycle's update. rd_data = acc[rd_idx*WORD_W +: WORD_W]. rd_idx >= NWORDS returns 0. rd_data holds its value when rd_req is low.
- Scan FSM states:
  - IDLE: on scan_start, set w=0, hit_cnt=0, go to LOAD.
  - LOAD: wbuf <= acc word w, go to EVAL.
  - EVAL, wbuf != 0: hit_vld=1 and hit_idx = w*WORD_W + lowest set bit of wbuf. On hit_rdy, clear that bit in wbuf and increment hit_cnt; stay in EVAL.
  - EVAL, wbuf == 0: if w == NWORDS-1 go to DONE, else w++ and go to LOAD.
  - DONE: scan_done=1 for one cycle, go to IDLE.
- Bits set in word w after that word's LOAD are not reported in the current pass.
- hit_vld and hit_idx derive only from registered state; hit_rdy never affects them in the same cycle.
- clr while scan_busy: next cycle is DONE with scan_abort=1. hit_cnt keeps its value. The accumulator clears.
- Reset values: acc=0, FSM=IDLE; rd_vld, rd_data, scan_busy, hit_vld, hit_idx, scan_done, scan_abort, hit_cnt, any_set all 0.
- Reset mid-scan: return to IDLE immediately; no scan_done.

## Timing
- Read latency 1: rd_req in cycle n gives rd_vld=1 and rd_data in cycle n+1. Back-to-back reads are allowed, one per cycle.
- Accumulate: mask_in in cycle n is visible to reads and any_set from cycle n+1.
- Scan with hit_rdy tied high and H set bits: scan_start in cycle 0, scan_busy from cycle 1, scan_done in cycle 2*NWORDS+1+H.
- Each stalled handshake cycle (hit_vld=1, hit_rdy=0) adds one cycle.
- scan_busy is high in LOAD, EVAL and DONE.

## Configuration
- EDGE_SCAN_CLR_EN defined: each accepted hit also clears its bit in acc in the same cycle. A same-cycle mask_vld setting that bit wins, so the bit stays 1. A full scan with no concurrent sets leaves acc = 0.
- EDGE_SCAN_CLR_EN undefined: the scan is read-only and acc is unaffected.

## Structure
- Package edge_accum_pkg holds:
  - the FSM state enum (IDLE, LOAD, EVAL, DONE);
  - default MASK_W and WORD_W;
  - a clog2 constant function.
- Sub-module edge_lsb_enc: WORD_W-bit lowest-set-bit priority encoder; outputs index plus nonzero flag. Used by EVAL.

## Test plan
- Reset, then mask_vld with bits 5 and 1000 set; rd_idx=0 and rd_idx=31 -> rd_data 0x00000020 and 0x00000100 one cycle later; any_set=1.
- Scan with hit_rdy=1 and bits {5, 1000, 2047} set -> hits 5, 1000, 2047 in order; hit_cnt=3; scan_done in cycle 132.
- Scan with an empty accumulator -> no hit_vld; scan_done in cycle 129; hit_cnt=0.
- Bit 40 set, hit_rdy held low 4 cycles -> hit_vld and hit_idx=40 stable for 4 cycles; scan_done is delayed 4 cycles.
- clr asserted in cycle 10 of a scan -> scan_done=1 with scan_abort=1 in cycle 11; acc=0; scan_busy=0 in cycle 12.
- With EDGE_SCAN_CLR_EN, bits {3, 70} set and a full scan -> acc=0 after scan_done; repeat with mask_vld setting bit 70 in its hit cycle -> bit 70 remains set.

Source files
------------

// File: rtl/edge_accum_pkg.sv
// rtl/edge_accum_pkg.sv - shared types, default widths and clog2 for the edge accumulator
package edge_accum_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_EVAL,
      S_DONE
   } scan_state_t;

   localparam int DEF_MASK_W = 2048;
   localparam int DEF_WORD_W = 32;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/edge_accum_scan_if.sv
// rtl/edge_accum_scan_if.sv - accumulate, word-read and hit-scan signal bundle
interface edge_accum_scan_if
   import edge_accum_pkg::*;
#(
   parameter int MASK_W = DEF_MASK_W,
   parameter int WORD_W = DEF_WORD_W
);
   localparam int NWORDS = MASK_W / WORD_W;
   localparam int IDX_W  = clog2(NWORDS);
   localparam int BIT_W  = clog2(MASK_W);

   logic              mask_vld;
   logic [MASK_W-1:0] mask_in;
   logic              clr;
   logic              rd_req;
   logic [IDX_W-1:0]  rd_idx;
   logic              rd_vld;
   logic [WORD_W-1:0] rd_data;
   logic              scan_start;
   logic              scan_busy;
   logic              hit_vld;
   logic              hit_rdy;
   logic [BIT_W-1:0]  hit_idx;
   logic              scan_done;
   logic              scan_abort;
   logic [BIT_W:0]    hit_cnt;
   logic              any_set;

   modport master (
      output mask_vld, mask_in, clr, rd_req, rd_idx, scan_start, hit_rdy,
      input  rd_vld, rd_data, scan_busy, hit_vld, hit_idx, scan_done,
             scan_abort, hit_cnt, any_set
   );

   modport slave (
      input  mask_vld, mask_in, clr, rd_req, rd_idx, scan_start, hit_rdy,
      output rd_vld, rd_data, scan_busy, hit_vld, hit_idx, scan_done,
             scan_abort, hit_cnt, any_set
   );

endinterface

// File: rtl/edge_lsb_enc.sv
// rtl/edge_lsb_enc.sv - lowest-set-bit priority encoder with nonzero flag
module edge_lsb_enc
   import edge_accum_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   localparam int LW = (clog2(WORD_W) < 1) ? 1 : clog2(WORD_W)
)(
   input  logic [WORD_W-1:0] i_word,
   output logic [LW-1:0]     o_idx,
   output logic              o_nz
);

   // Scan downward so the lowest set bit is the last one written.
   always_comb begin
      o_idx = '0;
      o_nz  = 1'b0;
      for (int i = WORD_W - 1; i >= 0; i--) begin
         if (i_word[i]) begin
            o_idx = LW'(i);
            o_nz  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/edge_accum_scan.sv
// rtl/edge_accum_scan.sv - sticky edge-mask accumulator, registered word read, hit-scan engine
// EDGE_SCAN_CLR_EN: accepted hits also clear their bit in the accumulator.
module edge_accum_scan
   import edge_accum_pkg::*;
#(
   parameter int MASK_W = DEF_MASK_W,
   parameter int WORD_W = DEF_WORD_W
)(
   input  logic             CLK,
   input  logic             RST,
   edge_accum_scan_if.slave bus
);
   localparam int NWORDS = MASK_W / WORD_W;
   localparam int IDX_W  = clog2(NWORDS);
   localparam int BIT_W  = clog2(MASK_W);
   localparam int LW     = clog2(WORD_W);

   scan_state_t       r_state;
   scan_state_t       w_state_nxt;
   logic [MASK_W-1:0] r_acc;
   logic [MASK_W-1:0] w_acc_nxt;
   logic [MASK_W-1:0] w_set;
   logic [IDX_W-1:0]  r_w;
   logic [WORD_W-1:0] r_wbuf;
   logic [BIT_W:0]    r_hit_cnt;
   logic              r_abort;
   logic              r_rd_vld;
   logic [WORD_W-1:0] r_rd_data;
   logic [WORD_W-1:0] w_rd_word;
   logic [WORD_W-1:0] w_load_word;
   logic [LW-1:0]     w_lsb_idx;
   logic              w_lsb_nz;
   logic              w_hit_vld;
   logic              w_hit_acc;
   logic [BIT_W-1:0]  w_hit_idx;
   logic              w_last_word;
   logic              w_scanning;

   edge_lsb_enc #(.WORD_W(WORD_W)) u_lsb_enc (
      .i_word (r_wbuf),
      .o_idx  (w_lsb_idx),
      .o_nz   (w_lsb_nz)
   );

   assign w_scanning  = (r_state == S_LOAD) || (r_state == S_EVAL);
   assign w_hit_vld   = (r_state == S_EVAL) && w_lsb_nz;
   assign w_hit_acc   = w_hit_vld && bus.hit_rdy && !bus.clr;
   // WORD_W is a power of two, so w*WORD_W + bit is a plain concatenation.
   assign w_hit_idx   = {r_w, w_lsb_idx};
   assign w_last_word = (r_w == IDX_W'(NWORDS - 1));
   assign w_load_word = r_acc[32'(r_w) * WORD_W +: WORD_W];
   assign w_rd_word   = (32'(bus.rd_idx) < 32'(NWORDS)) ?
                        r_acc[32'(bus.rd_idx) * WORD_W +: WORD_W] : '0;
   assign w_set       = bus.mask_vld ? bus.mask_in : '0;

`ifdef EDGE_SCAN_CLR_EN
   logic [MASK_W-1:0] w_hit_clr;
   assign w_hit_clr = w_hit_acc ? (MASK_W'(1) << w_hit_idx) : '0;
   // Setting after clearing lets a same-cycle producer bit survive the scan.
   assign w_acc_nxt = (r_acc & ~w_hit_clr) | w_set;
`else
   assign w_acc_nxt = r_acc | w_set;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_acc <= '0;
      end else if (bus.clr) begin
         r_acc <= '0;
      end else begin
         r_acc <= w_acc_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rd_vld  <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_rd_vld <= bus.rd_req;
         if (bus.rd_req) begin
            r_rd_data <= w_rd_word;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.scan_start) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_state_nxt = bus.clr ? S_DONE : S_EVAL;
         end
         S_EVAL: begin
            if (bus.clr) begin
               w_state_nxt = S_DONE;
            end else if (!w_lsb_nz) begin
               w_state_nxt = w_last_word ? S_DONE : S_LOAD;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_w       <= '0;
         r_wbuf    <= '0;
         r_hit_cnt <= '0;
         r_abort   <= 1'b0;
      end else begin
         if (r_state == S_IDLE && bus.scan_start) begin
            r_w       <= '0;
            r_hit_cnt <= '0;
            r_abort   <= 1'b0;
         end
         if (w_scanning && bus.clr) begin
            r_abort <= 1'b1;
         end
         if (r_state == S_LOAD) begin
            r_wbuf <= w_load_word;
         end
         if (w_hit_acc) begin
            r_wbuf    <= r_wbuf & (r_wbuf - 1'b1);
            r_hit_cnt <= r_hit_cnt + 1'b1;
         end
         if (r_state == S_EVAL && !bus.clr && !w_lsb_nz && !w_last_word) begin
            r_w <= r_w + 1'b1;
         end
      end
   end

   assign bus.rd_vld     = r_rd_vld;
   assign bus.rd_data    = r_rd_data;
   assign bus.scan_busy  = (r_state != S_IDLE);
   assign bus.hit_vld    = w_hit_vld;
   assign bus.hit_idx    = w_hit_vld ? w_hit_idx : '0;
   assign bus.scan_done  = (r_state == S_DONE);
   assign bus.scan_abort = (r_state == S_DONE) && r_abort;
   assign bus.hit_cnt    = r_hit_cnt;
   assign bus.any_set    = |r_acc;

endmodule

// File: tb/tb_edge_accum_scan.sv
// tb/tb_edge_accum_scan.sv - directed self-checking bench with hit scoreboard
module tb_edge_accum_scan;
   import edge_accum_pkg::*;

   localparam int MASK_W = 2048;
   localparam int WORD_W = 32;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;
   int   exp_hits[$];
   int   dc;
   logic ab;

   always #5 CLK = ~CLK;

   edge_accum_scan_if #(.MASK_W(MASK_W), .WORD_W(WORD_W)) bus ();

   edge_accum_scan #(.MASK_W(MASK_W), .WORD_W(WORD_W)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [MASK_W-1:0] bit_of(input int b);
      logic [MASK_W-1:0] m;
      m = '0;
      m[b] = 1'b1;
      return m;
   endfunction

   task automatic drive_mask(input logic [MASK_W-1:0] m);
      bus.mask_in  = m;
      bus.mask_vld = 1'b1;
      tick;
      bus.mask_vld = 1'b0;
      bus.mask_in  = '0;
   endtask

   task automatic pulse_clr;
      bus.clr = 1'b1;
      tick;
      bus.clr = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int idx, input logic [31:0] exp);
      bus.rd_req = 1'b1;
      bus.rd_idx = 6'(idx);
      tick;
      bus.rd_req = 1'b0;
      chk(tag, {bus.rd_vld, bus.rd_data}, {1'b1, exp});
   endtask

   task automatic scan_run(input int stall, input int clr_at, input int set_on_hit,
                           output int done_cyc, output logic aborted);
      int cyc;
      int st;
      int h;
      st       = stall;
      done_cyc = -1;
      aborted  = 1'b0;
      bus.scan_start = 1'b1;
      tick;
      bus.scan_start = 1'b0;
      cyc = 1;
      chk("busy_start", bus.scan_busy, 1);
      while (cyc < 400) begin
         bus.clr      = (cyc == clr_at);
         bus.mask_vld = 1'b0;
         bus.mask_in  = '0;
         bus.hit_rdy  = 1'b1;
         if (bus.scan_done) begin
            done_cyc = cyc;
            aborted  = bus.scan_abort;
            break;
         end
         if (bus.hit_vld) begin
            h = (exp_hits.size() > 0) ? exp_hits[0] : -1;
            if (st > 0) begin
               bus.hit_rdy = 1'b0;
               chk("hit_stall", 64'(bus.hit_idx), 64'(h));
               st--;
            end else begin
               chk("hit_idx", 64'(bus.hit_idx), 64'(h));
               if (exp_hits.size() > 0) void'(exp_hits.pop_front());
               if (h == set_on_hit) begin
                  bus.mask_vld = 1'b1;
                  bus.mask_in  = bit_of(h);
               end
            end
         end
         tick;
         cyc++;
      end
      bus.clr      = 1'b0;
      bus.mask_vld = 1'b0;
      bus.mask_in  = '0;
      bus.hit_rdy  = 1'b1;
   endtask

   initial begin
      bus.mask_vld   = 1'b0;
      bus.mask_in    = '0;
      bus.clr        = 1'b0;
      bus.rd_req     = 1'b0;
      bus.rd_idx     = '0;
      bus.scan_start = 1'b0;
      bus.hit_rdy    = 1'b1;
      RST = 1'b1;
      repeat (3) tick;
      chk("rst_read", {bus.rd_vld, bus.rd_data}, 0);
      chk("rst_scan", {bus.scan_busy, bus.hit_vld, bus.scan_done, bus.scan_abort}, 0);
      chk("rst_hit", {bus.hit_idx, bus.hit_cnt, bus.any_set}, 0);
      RST = 1'b0;
      tick;
      chk("idle_busy", bus.scan_busy, 0);

      drive_mask(bit_of(5) | bit_of(1000));
      chk("any_set", bus.any_set, 1);
      rd_chk("rd_w0", 0, 32'h0000_0020);
      rd_chk("rd_w31", 31, 32'h0000_0100);
      tick;
      chk("rd_hold", {bus.rd_vld, bus.rd_data}, {1'b0, 32'h0000_0100});

      bus.mask_in  = bit_of(2047);
      bus.mask_vld = 1'b1;
      bus.rd_req   = 1'b1;
      bus.rd_idx   = 6'd63;
      tick;
      bus.mask_vld = 1'b0;
      bus.mask_in  = '0;
      bus.rd_req   = 1'b0;
      chk("rd_pre_update", {bus.rd_vld, bus.rd_data}, {1'b1, 32'h0});
      rd_chk("rd_w63", 63, 32'h8000_0000);

      exp_hits.push_back(5);
      exp_hits.push_back(1000);
      exp_hits.push_back(2047);
      scan_run(0, -1, -1, dc, ab);
      chk("scan3_done_cyc", 64'(dc), 132);
      chk("scan3_abort", ab, 0);
      chk("scan3_cnt", bus.hit_cnt, 3);
      chk("scan3_sb_empty", 64'(exp_hits.size()), 0);
      tick;
      chk("scan3_idle", {bus.scan_busy, bus.scan_done, bus.hit_cnt}, {1'b0, 1'b0, 12'd3});
`ifdef EDGE_SCAN_CLR_EN
      chk("scan3_acc_cleared", bus.any_set, 0);
`else
      rd_chk("scan3_acc_kept_w0", 0, 32'h0000_0020);
      rd_chk("scan3_acc_kept_w63", 63, 32'h8000_0000);
`endif

      pulse_clr;
      chk("clr_idle", bus.any_set, 0);
      scan_run(0, -1, -1, dc, ab);
      chk("empty_done_cyc", 64'(dc), 129);
      chk("empty_cnt", bus.hit_cnt, 0);

      drive_mask(bit_of(40));
      exp_hits.push_back(40);
      scan_run(4, -1, -1, dc, ab);
      chk("stall_done_cyc", 64'(dc), 134);
      chk("stall_cnt", bus.hit_cnt, 1);
      chk("stall_sb_empty", 64'(exp_hits.size()), 0);

      pulse_clr;
      drive_mask(bit_of(3) | bit_of(500));
      exp_hits.push_back(3);
      exp_hits.push_back(500);
      scan_run(0, 10, -1, dc, ab);
      chk("abort_done_cyc", 64'(dc), 11);
      chk("abort_flag", ab, 1);
      chk("abort_cnt", bus.hit_cnt, 1);
      chk("abort_sb_left", 64'(exp_hits.size()), 1);
      exp_hits.delete();
      tick;
      chk("abort_busy12", {bus.scan_busy, bus.scan_done, bus.scan_abort}, 0);
      chk("abort_acc", bus.any_set, 0);
      rd_chk("abort_rd_w15", 15, 32'h0);

      drive_mask(bit_of(7));
      bus.scan_start = 1'b1;
      tick;
      bus.scan_start = 1'b0;
      repeat (3) tick;
      RST = 1'b1;
      tick;
      RST = 1'b0;
      chk("rst_mid_scan", {bus.scan_busy, bus.scan_done, bus.hit_vld, bus.hit_cnt, bus.any_set}, 0);
      tick;
      chk("rst_no_done", {bus.scan_busy, bus.scan_done}, 0);

      drive_mask(bit_of(3) | bit_of(70));
      exp_hits.push_back(3);
      exp_hits.push_back(70);
      scan_run(0, -1, -1, dc, ab);
      chk("s2_done_cyc", 64'(dc), 131);
      chk("s2_cnt", bus.hit_cnt, 2);
      tick;
`ifdef EDGE_SCAN_CLR_EN
      chk("s2_acc_cleared", bus.any_set, 0);
`else
      rd_chk("s2_acc_w2", 2, 32'h0000_0040);
      rd_chk("s2_acc_w0", 0, 32'h0000_0008);
`endif

      pulse_clr;
      drive_mask(bit_of(3) | bit_of(70));
      exp_hits.push_back(3);
      exp_hits.push_back(70);
      scan_run(0, -1, 70, dc, ab);
      chk("s3_done_cyc", 64'(dc), 131);
      chk("s3_sb_empty", 64'(exp_hits.size()), 0);
      tick;
      rd_chk("s3_bit70_kept", 2, 32'h0000_0040);
`ifdef EDGE_SCAN_CLR_EN
      rd_chk("s3_bit3_cleared", 0, 32'h0);
`else
      rd_chk("s3_bit3_kept", 0, 32'h0000_0008);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
